// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: in-order imem requests, DEPTH-slot circular buffer, valid/ready to decode.
// Optional `FETCH_PERF_EN adds saturating stall and discarded-response counters.
module fetch_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     pc_en,
  input  logic                     redirect,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_discards
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] tail, fill, head;
  logic [PW-1:0] discard_cnt;
  logic [PW-1:0] occ, pend;
  logic          has_credit, accept, pop, drop, write_fill;

  logic [DATA_WIDTH-1:0]    slot_instr [DEPTH];
  logic [ADDRESS_WIDTH-1:0] slot_pc    [DEPTH];

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    occ         = tail - head;
    pend        = tail - fill;
    // Credits count in-flight responses still owed to a flushed stream.
    has_credit  = ({1'b0, occ} + {1'b0, discard_cnt}) < DEPTH_W;
    imem_req    = rst && !redirect && has_credit;
    accept      = imem_req && imem_gnt;
    pc_en       = rst && (redirect || accept);
    instr_valid = rst && !redirect && (head != fill);
    pop         = instr_valid && instr_ready;
    drop        = imem_rvalid && (redirect || discard_cnt != '0);
    write_fill  = imem_rvalid && !redirect && discard_cnt == '0 && pend != '0;
  end

  assign imem_addr = pc;
  assign instr     = slot_instr[head[IW-1:0]];
  assign instr_pc  = slot_pc[head[IW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail        <= '0;
      fill        <= '0;
      head        <= '0;
      discard_cnt <= '0;
    end else if (redirect) begin
      tail        <= '0;
      fill        <= '0;
      head        <= '0;
      discard_cnt <= discard_cnt + pend - PW'(imem_rvalid);
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (imem_rvalid && discard_cnt != '0) discard_cnt <= discard_cnt - PW'(1);
      if (write_fill) fill <= fill + PW'(1);
      if (pop) head <= head + PW'(1);
    end
  end

  // NOTE: slot storage has no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (accept)     slot_pc[tail[IW-1:0]]    <= pc;
    if (write_fill) slot_instr[fill[IW-1:0]] <= imem_rdata;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_discards     <= '0;
    end else begin
      if (!imem_req && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (drop && perf_discards != '1)          perf_discards     <= perf_discards + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // A response must belong either to a live request or to a flushed one.
  resp_has_owner: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (pend != '0 || discard_cnt != '0));

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed table, hand sequences and random traffic
// checked against a queue-based model of the buffer and an in-order memory.
module tb_fetch_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          pc_en;
  logic          redirect;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_discards;
`endif

  fetch_buffer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_discards(perf_discards)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] data; bit filled; } entry_t;
  typedef struct { int due; logic [AW-1:0] addr; } mreq_t;
  typedef struct {
    logic gnt, rv, rdy;
    logic exp_req, exp_pc_en, exp_valid;
    logic [AW-1:0] exp_ipc;
  } vec_t;

  entry_t bq[$];
  mreq_t  mq[$];
  int discards, model_stalls, model_drops, cyc, last_due;
  int lat_min = 1, lat_max = 1;
  bit auto_mem;
  logic [AW-1:0] target;
  logic exp_req, exp_pc_en, exp_valid;
  int n_checks = 0, n_passed = 0;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
  endtask

  task automatic model_clear();
    bq.delete(); mq.delete();
    discards = 0; model_stalls = 0; model_drops = 0; last_due = -1; pc = '0;
  endtask

  task automatic drive_and_check();
    if (auto_mem) begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1; imem_rdata = memfn(mq[0].addr);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
    end
    exp_req   = !redirect && (bq.size() + discards < DEPTH);
    exp_pc_en = redirect || (exp_req && imem_gnt);
    exp_valid = !redirect && bq.size() > 0 && bq[0].filled;
    @(negedge clk);
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, pc);
    check("pc_en", pc_en, exp_pc_en);
    check("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      check("instr", instr, bq[0].data);
      check("instr_pc", instr_pc, bq[0].pc);
    end
`ifdef FETCH_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, model_stalls);
    check("perf_discards", perf_discards, model_drops);
`endif
  endtask

  task automatic advance();
    bit done;
    int pend, due;
    @(posedge clk);
    #1;
    if (redirect) begin
      pend = 0;
      foreach (bq[i]) if (!bq[i].filled) pend++;
      if (imem_rvalid) model_drops++;
      discards = discards + pend - (imem_rvalid ? 1 : 0);
      bq.delete();
    end else begin
      if (imem_rvalid) begin
        if (discards > 0) begin
          discards--; model_drops++;
        end else begin
          done = 0;
          for (int i = 0; i < bq.size(); i++)
            if (!done && !bq[i].filled) begin
              bq[i].data = imem_rdata; bq[i].filled = 1; done = 1;
            end
        end
      end
      if (exp_valid && instr_ready) bq.delete(0);
      if (exp_req && imem_gnt) begin
        bq.push_back('{pc: pc, data: '0, filled: 0});
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        mq.push_back('{due: due, addr: pc});
        last_due = due;
      end
    end
    if (!exp_req) model_stalls++;
    if (auto_mem && imem_rvalid) mq.delete(0);
    if (exp_pc_en) pc = redirect ? target : pc + 32'd4;
    cyc++;
  endtask

  task automatic step();
    drive_and_check();
    advance();
  endtask

  task automatic wait_valid(input int max_cycles, output bit found);
    found = 0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      drive_and_check();
      if (instr_valid === 1'b1) found = 1;
      else advance();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; instr_ready = 1'b1;
    #1;
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
`ifdef FETCH_PERF_EN
    check("rst_perf_stall", perf_stall_cycles, 32'd0);
    check("rst_perf_discards", perf_discards, 32'd0);
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0; target = '0;
  endtask

  vec_t vecs[10];
  bit   found;
  int   first;
  logic [AW-1:0] nexp_pc;

  initial begin
    // gnt, rv, rdy | req, pc_en, valid, head pc
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hc};

    cyc = 0; imem_rdata = '0; auto_mem = 0;
    do_reset();

    // Fill to DEPTH with decode stalled, then drain.
    for (int i = 0; i < 10; i++) begin
      imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv; instr_ready = vecs[i].rdy;
      imem_rdata = 32'hd000_0000 | i;
      drive_and_check();
      check("tbl_req", imem_req, vecs[i].exp_req);
      check("tbl_pc_en", pc_en, vecs[i].exp_pc_en);
      check("tbl_valid", instr_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check("tbl_instr_pc", instr_pc, vecs[i].exp_ipc);
      advance();
    end
    imem_rvalid = 1'b0;

    // Streaming at one instruction per cycle.
    do_reset();
    auto_mem = 1; lat_min = 1; lat_max = 1; imem_gnt = 1; instr_ready = 1;
    first = -1; nexp_pc = '0;
    for (int c = 0; c < 16; c++) begin
      drive_and_check();
      if (instr_valid === 1'b1) begin
        if (first < 0) first = c;
        check("stream_pc", instr_pc, nexp_pc);
        check("stream_data", instr, memfn(nexp_pc));
        nexp_pc += 32'd4;
      end
      check("stream_pc_en", pc_en, 1'b1);
      advance();
    end
    check("first_valid_latency", first, 2);

    // Grant withheld: PC must hold.
    do_reset();
    auto_mem = 1; instr_ready = 1; imem_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      drive_and_check();
      check("nogrant_pc_en", pc_en, 1'b0);
      check("nogrant_addr", imem_addr, 32'h0);
      advance();
    end
    imem_gnt = 1;
    drive_and_check();
    check("grant_pc_en", pc_en, 1'b1);
    advance();
    imem_gnt = 0;
    drive_and_check();
    check("single_accept_addr", imem_addr, 32'h4);
    check("single_accept_pc_en", pc_en, 1'b0);
    advance();
    wait_valid(10, found);
    check("nogrant_valid_seen", found, 1'b1);
    if (found) begin check("nogrant_instr_pc", instr_pc, 32'h0); advance(); end

    // Redirect with three requests in flight.
    do_reset();
    auto_mem = 1; lat_min = 4; lat_max = 4; imem_gnt = 1; instr_ready = 1;
    repeat (3) step();
    redirect = 1; target = 32'h100;
    drive_and_check();
    check("redirect_hides_valid", instr_valid, 1'b0);
    check("redirect_no_req", imem_req, 1'b0);
    advance();
    redirect = 0;
    wait_valid(30, found);
    check("redirect_valid_seen", found, 1'b1);
    if (found) begin
      check("redirect_first_pc", instr_pc, 32'h100);
      check("redirect_first_instr", instr, memfn(32'h100));
`ifdef FETCH_PERF_EN
      check("redirect_perf_discards", perf_discards, 32'd3);
`endif
      advance();
    end

    // Redirect coincident with a response, two pending.
    do_reset();
    auto_mem = 1; lat_min = 2; lat_max = 2; imem_gnt = 1; instr_ready = 1;
    repeat (2) step();
    redirect = 1; target = 32'h200;
    drive_and_check();
    check("coincident_rvalid", imem_rvalid, 1'b1);
    advance();
    redirect = 0;
    wait_valid(30, found);
    check("coincident_valid_seen", found, 1'b1);
    if (found) begin
      check("coincident_first_pc", instr_pc, 32'h200);
      check("coincident_first_instr", instr, memfn(32'h200));
`ifdef FETCH_PERF_EN
      check("coincident_perf_discards", perf_discards, 32'd2);
`endif
      advance();
    end

    // Reset mid-stream with two filled slots.
    do_reset();
    auto_mem = 1; lat_min = 1; lat_max = 1; imem_gnt = 1; instr_ready = 0;
    repeat (2) step();
    imem_gnt = 0;
    repeat (2) step();
    drive_and_check();
    check("pre_reset_valid", instr_valid, 1'b1);
    advance();
    do_reset();
    auto_mem = 1; imem_gnt = 1; instr_ready = 1;
    wait_valid(10, found);
    check("post_reset_valid_seen", found, 1'b1);
    if (found) begin check("post_reset_first_pc", instr_pc, 32'h0); advance(); end
    repeat (8) step();

    // Random traffic against the model.
    lat_min = 1; lat_max = 5;
    for (int c = 0; c < 1500; c++) begin
      imem_gnt    = ($urandom_range(3, 0) != 0);
      instr_ready = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(15, 0) == 0);
      target      = {$urandom_range(32'hffff, 0), 2'b00};
      step();
    end
    redirect = 0;

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Instruction fetch stage directly downstream of the program counter block. Takes the current PC, issues in-order requests to instruction memory over a req/gnt + rvalid interface, and holds returned instructions with their PCs in a DEPTH-slot circular buffer. Drives decode with a valid/ready handshake. Generates the PC-advance enable, and flushes the buffer and discards in-flight responses on a taken-branch redirect.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction width
DEPTH, 4, number of buffer slots; power of two, minimum 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
pc  input  ADDRESS_WIDTH  current PC from the PC register
pc_en  output  1  PC register load enable; PC advances (or takes branch) when 1
redirect  input  1  taken branch/jump (same as PCsrc); flush request
imem_req  output  1  fetch request valid
imem_addr  output  ADDRESS_WIDTH  fetch address; equals pc
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid; responses return in request order, latency ≥1 cycle
imem_rdata  input  DATA_WIDTH  response instruction
instr_valid  output  1  buffer head holds a filled instruction
instr_ready  input  1  decode accepts head
instr  output  DATA_WIDTH  head instruction
instr_pc  output  ADDRESS_WIDTH  PC of head instruction

Behaviour:
- Slot state: tail (allocate), fill (next to fill), head (next to pop) pointers, log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; occ = tail-head; pend = tail-fill; discard_cnt 0..DEPTH.
- Reset (rst=0, async): all pointers 0, discard_cnt 0. Outputs while rst=0: instr_valid=0, imem_req=0, pc_en=0. Slot contents undefined.
- Request: imem_req = !redirect && (occ + discard_cnt < DEPTH). imem_addr = pc (combinational). Accept = imem_req & imem_gnt: allocate slot at tail, store pc, tail++.
- pc_en = redirect | (imem_req & imem_gnt), combinational. The PC holds while a request is pending without grant.
- Response: on imem_rvalid, if discard_cnt>0, drop data and decrement discard_cnt. Otherwise write imem_rdata into slot[fill] and fill++. An rvalid with pend=0 and discard_cnt=0 is a protocol error; assertion only, state unchanged.
- Output: instr_valid = (head != fill) && !redirect. instr/instr_pc = slot[head], registered storage, zero-latency read. Pop on instr_valid & instr_ready: head++.
- Minimum latency from grant to instr_valid: response cycle + 1 (data registered into slot, visible next cycle).
- Full: occ + discard_cnt == DEPTH, so imem_req=0 and pc_en=0. Same-cycle pop does not free a credit until the next cycle; request gating uses registered occupancy only.
- Empty: head==fill, so instr_valid=0. No bypass from imem_rdata to instr.
- Redirect (edge where redirect=1):
  - head=fill=tail=0.
  - discard_cnt <= discard_cnt + pend - (rvalid this cycle ? 1 : 0). A response arriving in the redirect cycle is itself dropped.
  - No request issued and no pop in that cycle.
  - Requests resume the next cycle if credits allow. Discarded responses always precede responses for new requests.
- Simultaneous accept, response and pop in one cycle: all three pointer updates apply independently.
- Reset mid-operation: everything cleared immediately. In-flight memory responses after reset release are the memory's responsibility; the bench must not drive them.

Optional Feature:
FETCH_PERF_EN. When defined, adds two outputs:
- perf_stall_cycles [31:0]: counts cycles with imem_req=0 while rst=1.
- perf_discards [31:0]: counts dropped responses.
Both are saturating at 2^32-1, reset to 0, and never wrap. When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then pc=0x0, gnt=1, 1-cycle memory latency, instr_ready=1 → pc_en=1 every cycle; instr_pc sequence 0x0,0x4,0x8… with instr matching memory; first instr_valid 2 cycles after first grant.
- instr_ready=0, gnt=1 → exactly 4 accepts (DEPTH=4), then imem_req=0 and pc_en=0; raise ready → 4 pops in order, requests resume one cycle after the first pop.
- gnt held 0 for 3 cycles → imem_addr stable at pc, pc_en=0; gnt=1 → single accept.
- 3 requests outstanding (latency 4), pulse redirect with target 0x100 → instr_valid=0 that cycle; next 3 rvalids dropped (perf_discards=3 when enabled); first delivered instruction has instr_pc=0x100.
- redirect coincident with an rvalid and 2 pending → discard_cnt=1; only one further response dropped.
- Assert rst low mid-stream with 2 slots full → instr_valid, imem_req, pc_en all 0 immediately; after release, fetch restarts cleanly.
